counter_checker: RTL and testbench
==================================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the monitored count.
REQ-002 Parameter LOCK_CNT, default 3: consecutive correct increments required to declare lock (legal range 1..15).
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 clock  input  1  rising-edge clock shared with the monitored counter.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  sample qualifier; count_in is evaluated only on edges where en=1.
REQ-007 count_in  input  WIDTH  count value from the counter under observation.
REQ-008 locked  output  1  high while in LOCK state.
REQ-009 err  output  1  sequence-error indication (see REQ-020, REQ-027/028).
REQ-010 wrap  output  1  one-cycle pulse on a correct max-to-zero rollover while locked.
REQ-011 err_count  output  ERR_W  saturating count of sequence errors detected in LOCK.

Function
REQ-012 The block SHALL hold registers prev[WIDTH-1:0], run[3:0], state in {IDLE, ACQ, LOCK}; all outputs are registered.
REQ-013 The block SHALL define a sample as match when count_in == (prev + 1) mod 2^WIDTH; max (all ones) followed by 0 is a match.
REQ-014 On every edge with en=1 the block SHALL load prev <= count_in, in every state.
REQ-015 IDLE, en=1: the block SHALL set run <= 0 and go to ACQ; no err, no wrap.
REQ-016 ACQ, en=1, match: the block SHALL increment run; if run+1 == LOCK_CNT, go to LOCK and clear run.
REQ-017 ACQ, en=1, mismatch: the block SHALL clear run, stay in ACQ, and not assert err or change err_count.
REQ-018 LOCK, en=1, match: the block SHALL stay in LOCK; wrap SHALL pulse high for exactly one cycle when prev == 2^WIDTH-1 and count_in == 0.
REQ-019 LOCK, en=1, mismatch: the block SHALL go to ACQ with run <= 0 and increment err_count, holding at 2^ERR_W-1 (no wrap-around).
REQ-020 A LOCK mismatch SHALL set err on the same edge that updates err_count.
REQ-021 With en=0 the block SHALL hold prev, run, state and err_count, and SHALL drive wrap low (err per REQ-027/028).
REQ-022 locked SHALL equal (state == LOCK); it falls on the edge that detects the mismatch.
REQ-023 Lock latency: from IDLE, a clean increasing sequence SHALL assert locked after LOCK_CNT+1 qualified edges.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force state=IDLE, prev=0, run=0, locked=0, err=0, wrap=0, err_count=0, regardless of clock.
REQ-025 Reset asserted mid-sequence SHALL discard all history; after release, lock SHALL require the full REQ-023 latency again.
REQ-026 The first edge after reset release with en=1 SHALL be treated as the IDLE sample.

Configuration
REQ-027 With macro COUNTER_CHECKER_STICKY_EN defined, err SHALL stay high from the first LOCK mismatch until reset.
REQ-028 Without COUNTER_CHECKER_STICKY_EN, err SHALL be a one-cycle pulse per LOCK mismatch and low otherwise.

Verification
REQ-029 Reset 2 cycles, en=1, count_in 0,1,2,3,4 -> locked=0 through sample 3, locked=1 after the edge sampling 3; err=0, err_count=0.
REQ-030 Locked, count_in ...14,15,0,1 -> wrap=1 for exactly one cycle after the edge sampling 0; locked stays 1; err=0.
REQ-031 Locked at 5, then 5,7 -> after sampling 7: locked=0, err_count=1, err=1 (pulse without macro, stays 1 with macro); then 8,9,10,11 -> locked=1 again, err_count still 1.
REQ-032 Locked at 3, en=0 for 5 cycles with count_in=9, then en=1 with 4 -> no err, locked stays 1, wrap stays 0.
REQ-033 ERR_W=2, force 5 LOCK mismatches (relocking between them) -> err_count sequence 1,2,3,3,3.
REQ-034 Locked at 6, assert reset between clock edges -> all outputs 0 immediately; release, feed 7,8,9 -> locked=0; feed 10 -> locked=1.

Source files
------------

// File: rtl/counter_checker.sv
// Monitors an external counter: acquires lock after LOCK_CNT clean increments, flags sequence errors while locked.
// Optional build macro COUNTER_CHECKER_STICKY_EN keeps err high from the first locked error until reset.
module counter_checker #(
   parameter int WIDTH    = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] count_in,
   output logic             locked,
   output logic             err,
   output logic             wrap,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] prev_q;
   logic [3:0]       run_q;
   logic             locked_q, err_q, wrap_q;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [WIDTH-1:0] prev_inc;
   logic [3:0]       run_inc;
   logic             match;

   // Sized intermediate so max+1 truncates to zero before the compare
   assign prev_inc    = prev_q + 1'b1;
   assign match       = (count_in == prev_inc);
   assign run_inc     = run_q + 4'd1;
   assign err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         run_q       <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         err_count_q <= '0;
      end else begin
         wrap_q <= 1'b0;
`ifndef COUNTER_CHECKER_STICKY_EN
         err_q  <= 1'b0;
`endif
         if (en) begin
            prev_q <= count_in;
            case (state_q)
               IDLE: begin
                  run_q   <= '0;
                  state_q <= ACQ;
               end
               ACQ: begin
                  if (match) begin
                     if (run_inc == 4'(LOCK_CNT)) begin
                        state_q  <= LOCK;
                        run_q    <= '0;
                        locked_q <= 1'b1;
                     end else begin
                        run_q <= run_inc;
                     end
                  end else begin
                     run_q <= '0;
                  end
               end
               LOCK: begin
                  if (match) begin
                     // a match landing on zero can only come from all-ones
                     wrap_q <= (count_in == '0);
                  end else begin
                     state_q     <= ACQ;
                     run_q       <= '0;
                     locked_q    <= 1'b0;
                     err_q       <= 1'b1;
                     err_count_q <= err_count_d;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign locked    = locked_q;
   assign err       = err_q;
   assign wrap      = wrap_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: directed vector table, hand-built reset/saturation sequences, random vs. a reference model.
module tb_counter_checker;
   localparam int W  = 4;
   localparam int LC = 3;

   logic         clock = 1'b0;
   logic         reset;
   logic         en;
   logic [W-1:0] count_in;
   logic         a_locked, a_err, a_wrap;
   logic [7:0]   a_cnt;
   logic         b_locked, b_err, b_wrap;
   logic [1:0]   b_cnt;

   counter_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) dut_a (
      .clock(clock), .reset(reset), .en(en), .count_in(count_in),
      .locked(a_locked), .err(a_err), .wrap(a_wrap), .err_count(a_cnt));
   counter_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) dut_b (
      .clock(clock), .reset(reset), .en(en), .count_in(count_in),
      .locked(b_locked), .err(b_err), .wrap(b_wrap), .err_count(b_cnt));

   always #5 clock = ~clock;

   typedef struct {
      logic         en;
      logic [W-1:0] cin;
      logic         l;
      logic         e;
      logic         w;
      int           n;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   seen_err = 0;

   // reference model state
   bit m_started, m_locked, m_err, m_wrap;
   int m_prev, m_streak, m_errs;

   function automatic void add(logic e_, int c, logic l, logic e, logic w, int n);
      vec_t v;
      v.en = e_; v.cin = W'(c); v.l = l; v.e = e; v.w = w; v.n = n;
      tbl.push_back(v);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all(string tag, logic l, logic e, logic w, int n);
      int nb;
      nb = (n > 3) ? 3 : n;
      chk({tag, ".locked"},  int'(a_locked), int'(l));
      chk({tag, ".err"},     int'(a_err),    int'(e));
      chk({tag, ".wrap"},    int'(a_wrap),   int'(w));
      chk({tag, ".errcnt"},  int'(a_cnt),    n);
      chk({tag, ".b_lock"},  int'(b_locked), int'(l));
      chk({tag, ".b_err"},   int'(b_err),    int'(e));
      chk({tag, ".b_errcnt"}, int'(b_cnt),   nb);
   endtask

   // directed expectations give err as a pulse; the sticky build holds it
   task automatic check_pulse(string tag, logic l, logic e, logic w, int n);
      logic ee;
`ifdef COUNTER_CHECKER_STICKY_EN
      seen_err = seen_err | e;
      ee = seen_err;
`else
      ee = e;
`endif
      check_all(tag, l, ee, w, n);
   endtask

   task automatic step(logic e, int c);
      en = e;
      count_in = W'(c);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      seen_err = 0;
   endtask

   function automatic void m_reset();
      m_started = 0; m_locked = 0; m_err = 0; m_wrap = 0;
      m_prev = 0; m_streak = 0; m_errs = 0;
   endfunction

   function automatic void m_step(logic e, int c);
      bit match;
      m_wrap = 0;
`ifndef COUNTER_CHECKER_STICKY_EN
      m_err = 0;
`endif
      if (!e) return;
      match = (c == ((m_prev + 1) % (1 << W)));
      if (!m_started) begin
         m_started = 1;
         m_streak = 0;
      end else if (m_locked) begin
         if (match) m_wrap = (m_prev == (1 << W) - 1) && (c == 0);
         else begin
            m_locked = 0; m_streak = 0; m_errs++; m_err = 1;
         end
      end else if (match) begin
         m_streak++;
         if (m_streak == LC) begin
            m_locked = 1; m_streak = 0;
         end
      end else m_streak = 0;
      m_prev = c;
   endfunction

   initial begin
      int p;
      reset = 1'b1;
      en = 1'b0;
      count_in = '0;

      // lock-up, rollover, error/relock, en=0 hold
      add(1, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0); add(1, 2, 0, 0, 0, 0);
      add(1, 3, 1, 0, 0, 0); add(1, 4, 1, 0, 0, 0);
      for (int c = 5; c <= 15; c++) add(1, c, 1, 0, 0, 0);
      add(1, 0, 1, 0, 1, 0); add(1, 1, 1, 0, 0, 0);
      for (int c = 2; c <= 5; c++) add(1, c, 1, 0, 0, 0);
      add(1, 7, 0, 1, 0, 1); add(1, 8, 0, 0, 0, 1); add(1, 9, 0, 0, 0, 1);
      add(1, 10, 1, 0, 0, 1); add(1, 11, 1, 0, 0, 1);
      for (int c = 12; c <= 15; c++) add(1, c, 1, 0, 0, 1);
      add(1, 0, 1, 0, 1, 1); add(0, 9, 1, 0, 0, 1);
      for (int c = 1; c <= 3; c++) add(1, c, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, 9, 1, 0, 0, 1);
      add(1, 4, 1, 0, 0, 1);

      @(posedge clock); #1;
      check_all("rst", 0, 0, 0, 0);
      do_reset();
      check_all("rst_rel", 0, 0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].en, int'(tbl[i].cin));
         check_pulse($sformatf("tbl%0d", i), tbl[i].l, tbl[i].e, tbl[i].w, tbl[i].n);
      end

      // reset between edges while locked wipes everything at once
      step(1, 5); check_pulse("pre5", 1, 0, 0, 1);
      step(1, 6); check_pulse("pre6", 1, 0, 0, 1);
      #2 reset = 1'b1;
      #1 check_all("async_rst", 0, 0, 0, 0);
      en = 1'b1; count_in = 4'd7;
      @(posedge clock); #1;
      check_all("rst_hold", 0, 0, 0, 0);
      reset = 1'b0;
      seen_err = 0;
      step(1, 7); check_pulse("relock7", 0, 0, 0, 0);
      step(1, 8); check_pulse("relock8", 0, 0, 0, 0);
      step(1, 9); check_pulse("relock9", 0, 0, 0, 0);
      step(1, 10); check_pulse("relock10", 1, 0, 0, 0);

      // repeated locked errors: 2-bit counter saturates at 3
      p = 10;
      for (int k = 0; k < 5; k++) begin
         p = (p + 2) % 16;
         step(1, p);
         check_pulse($sformatf("sat%0d", k), 0, 1, 0, k + 1);
         for (int j = 0; j < 3; j++) begin
            p = (p + 1) % 16;
            step(1, p);
            check_pulse($sformatf("sat%0d_r%0d", k, j), (j == 2), 0, 0, k + 1);
         end
      end

      // random traffic against the reference model
      do_reset();
      m_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            m_reset();
            check_all("rnd_rst", 0, 0, 0, 0);
         end else begin
            logic e;
            int   c;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : (m_prev + 1) % 16;
            step(e, c);
            m_step(e, c);
            check_all($sformatf("rnd%0d", i), m_locked, m_err, m_wrap, m_errs > 255 ? 255 : m_errs);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
